// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, totals and counter types for the parallax core.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 24;
  localparam int unsigned H_SYNC_DEF    = 40;
  localparam int unsigned H_BP_DEF      = 128;
  localparam int unsigned H_TOTAL_DEF   = 832;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 9;
  localparam int unsigned V_SYNC_DEF    = 3;
  localparam int unsigned V_BP_DEF      = 28;
  localparam int unsigned V_TOTAL_DEF   = 520;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned RED_Y_MIN = 360;

  typedef logic [CNT_W-1:0] h_cnt_t;
  typedef logic [CNT_W-1:0] v_cnt_t;
  typedef logic [CNT_W-1:0] frame_cnt_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters, frame tick and raw (unregistered) syncs.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  output h_cnt_t h,
  output v_cnt_t v,
  output logic   frame_tick,
  output logic   hsync_raw,
  output logic   vsync_raw
);

  localparam h_cnt_t H_LAST   = h_cnt_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam v_cnt_t V_LAST   = v_cnt_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam h_cnt_t HS_START = h_cnt_t'(H_VISIBLE + H_FP);
  localparam h_cnt_t HS_END   = h_cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam v_cnt_t VS_START = v_cnt_t'(V_VISIBLE + V_FP);
  localparam v_cnt_t VS_END   = v_cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) v <= '0;
      else             v <= v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    frame_tick = (h == H_LAST) && (v == V_LAST);
    hsync_raw  = !((h >= HS_START) && (h <= HS_END));
    vsync_raw  = !((v >= VS_START) && (v <= VS_END));
  end

endmodule

// File: rtl/vga_parallax_core.sv
// VGA parallax pattern generator; scrolling layers enabled by PARALLAX_EN,
// otherwise the frame counter is dropped and the image is static.
module vga_parallax_core
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam h_cnt_t H_VIS = h_cnt_t'(H_VISIBLE);
  localparam v_cnt_t V_VIS = v_cnt_t'(V_VISIBLE);
  localparam v_cnt_t Y_RED = v_cnt_t'(RED_Y_MIN);

  h_cnt_t     h;
  v_cnt_t     v;
  frame_cnt_t f;
  logic       frame_tick;
  logic       hsync_raw;
  logic       vsync_raw;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .h          (h),
    .v          (v),
    .frame_tick (frame_tick),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw)
  );

`ifdef PARALLAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          f <= '0;
    else if (frame_tick) f <= f + 1'b1;
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign f = '0;
`endif

  h_cnt_t     x_blue;
  h_cnt_t     x_green;
  h_cnt_t     x_red;
  logic [2:0] rgb_next;

  // Layer offsets wrap at 10 bits, so the shifted frame counter is truncated deliberately.
  always_comb begin
    x_blue   = h + f;
    x_green  = h + (f << 1);
    x_red    = h + (f << 2);
    rgb_next = '0;
    if ((h < H_VIS) && (v < V_VIS)) begin
      rgb_next = {x_red[3] & (v >= Y_RED), x_green[4], x_blue[5] ^ v[5]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= hsync_raw;
      vsync <= vsync_raw;
      rgb   <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_parallax_core.sv
// Self-checking bench for vga_parallax_core on a reduced raster; honours PARALLAX_EN.
module tb_vga_parallax_core;

  localparam int unsigned HV  = 64;
  localparam int unsigned HFP = 4;
  localparam int unsigned HS  = 8;
  localparam int unsigned HBP = 4;
  localparam int unsigned VV  = 368;
  localparam int unsigned VFP = 2;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 4;
  localparam int unsigned HT  = HV + HFP + HS + HBP;
  localparam int unsigned VT  = VV + VFP + VS + VBP;
  localparam int unsigned FT  = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned k = 0;

  int unsigned hfall1 = 0, hfall2 = 0, hrise1 = 0;
  int unsigned vfall1 = 0, vfall2 = 0, vrise1 = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  vga_parallax_core #(
    .H_VISIBLE (HV),
    .H_FP      (HFP),
    .H_SYNC    (HS),
    .H_BP      (HBP),
    .V_VISIBLE (VV),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VBP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hsync (hsync),
    .vsync (vsync),
    .rgb   (rgb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Expected {hsync, vsync, rgb} for the idx-th pixel since reset release.
  function automatic logic [4:0] model(input int unsigned idx);
    int unsigned h, v, f, xb, xg, xr;
    logic hs, vs;
    logic [2:0] c;
    h = idx % HT;
    v = (idx / HT) % VT;
`ifdef PARALLAX_EN
    f = (idx / FT) % 1024;
`else
    f = 0;
`endif
    hs = !(h >= HV + HFP && h < HV + HFP + HS);
    vs = !(v >= VV + VFP && v < VV + VFP + VS);
    c = 3'b000;
    if (h < HV && v < VV) begin
      xb = (h + f) % 1024;
      xg = (h + 2 * f) % 1024;
      xr = (h + 4 * f) % 1024;
      c[0] = ((xb / 32) % 2 == 1) ^ ((v / 32) % 2 == 1);
      c[1] = (xg / 16) % 2 == 1;
      c[2] = ((xr / 8) % 2 == 1) && (v >= 360);
    end
    return {hs, vs, c};
  endfunction

  task automatic run_cycles(input int unsigned n, input bit track);
    logic [4:0] e;
    int unsigned idx, h, v, fr;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      idx = k - 1;
      e = model(idx);
      check_eq("hsync", hsync, e[4]);
      check_eq("vsync", vsync, e[3]);
      check_eq("rgb", rgb, e[2:0]);
      h = idx % HT;
      v = (idx / HT) % VT;
      fr = idx / FT;
      if (fr == 0 && v == 0 && h == 32) check_eq("pix_32_0", rgb, 1);
      if (fr == 0 && v == 0 && h == 16) check_eq("pix_16_0", rgb, 2);
      if (fr == 0 && v == 360 && h == 8) check_eq("pix_8_360", rgb, 5);
`ifdef PARALLAX_EN
      if (fr == 1 && v == 0 && h == 31) check_eq("scroll_blue", rgb[0], 1);
`else
      if (fr == 1 && v == 0 && h == 31) check_eq("static_blue", rgb[0], 0);
`endif
      if (track) begin
        if (prev_hs && !hsync) begin
          if (hfall1 == 0) hfall1 = k;
          else if (hfall2 == 0) hfall2 = k;
        end
        if (!prev_hs && hsync && hfall1 != 0 && hrise1 == 0) hrise1 = k;
        if (prev_vs && !vsync) begin
          if (vfall1 == 0) vfall1 = k;
          else if (vfall2 == 0) vfall2 = k;
        end
        if (!prev_vs && vsync && vfall1 != 0 && vrise1 == 0) vrise1 = k;
        prev_hs = hsync;
        prev_vs = vsync;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hsync"}, hsync, 1);
    check_eq({tag, "_vsync"}, vsync, 1);
    check_eq({tag, "_rgb"}, rgb, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    k = 0;
    run_cycles(2 * FT + 2 * HT, 1'b1);

    check_eq("hs_first_fall", hfall1, HV + HFP + 1);
    check_eq("hs_low_len", hrise1 - hfall1, HS);
    check_eq("hs_period", hfall2 - hfall1, HT);
    check_eq("vs_first_fall", vfall1, (VV + VFP) * HT + 1);
    check_eq("vs_low_len", vrise1 - vfall1, VS * HT);
    check_eq("vs_period", vfall2 - vfall1, FT);

    for (int r = 0; r < 3; r++) begin
      run_cycles($urandom_range(4000, 50), 1'b0);
      #($urandom_range(3, 1));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      check_reset_outputs("held_reset");
      rst_n = 1'b1;
      k = 0;
      run_cycles(2 * HT + $urandom_range(200, 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
